nios2_fp_jtag_scan_master: RTL

Host-side initiator for the Nios II JTAG debug link. Converts IR/DR scan commands into TCK/TMS/TDI bit sequences that walk the IEEE 1149.1 TAP state machine, and returns the captured TDO bits as a response word. It drives the debug-module TAP from the opposite end, for in-system exercising of the on-chip debug path and for closed-loop simulation against the CPU's debug TCK logic.

---
 rtl/nios2_fp_jtag_pkg.sv | 10 +
 rtl/nios2_fp_jtag_tck_gen.sv | 32 +++
 rtl/nios2_fp_jtag_scan_master.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/nios2_fp_jtag_pkg.sv
// nios2_fp_jtag_pkg: shared constants and FSM state encoding for the JTAG scan master
// Contents: MAX_LEN (longest scan), LEN_W (length field width), TLR_CYCLES (TMS=1 cycles for TAP reset), state_t
package nios2_fp_jtag_pkg;
    localparam int MAX_LEN = 38;
    localparam int LEN_W = 6;
    localparam int TLR_CYCLES = 5;
    typedef enum logic [3:0] {
        IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RUN_IDLE, RESP, TLR, TLR_RTI
    } state_t;
endpackage

// File: rtl/nios2_fp_jtag_tck_gen.sv
// nios2_fp_jtag_tck_gen: divides clk into a 50% duty TCK and flags the cycles that move it
// Ports: clk, reset_n (async, active low), en (run TCK, else hold low),
//        tck (JTAG clock), rise/fall (high in the clk cycle whose edge drives tck high/low)
module nios2_fp_jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tck,
    output logic rise,
    output logic fall
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [CW-1:0] cnt;
    logic hit;
    assign hit = en && cnt == CW'(CLK_DIV - 1);
    assign rise = hit && !tck;
    assign fall = hit && tck;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else begin
            cnt <= hit ? '0 : cnt + 1'b1;
            tck <= tck ^ hit;
        end
    end
endmodule

// File: rtl/nios2_fp_jtag_scan_master.sv
// nios2_fp_jtag_scan_master: turns IR/DR scan commands into TCK/TMS/TDI sequences and returns captured TDO
// Ports: clk, reset_n (async, active low); cmd_valid/cmd_ready/cmd_is_ir/cmd_len/cmd_data (command, LSB first);
//        rsp_valid/rsp_ready/rsp_data (captured TDO, LSB first); busy; tck/tms/tdi/tdo (JTAG pins)
// Option: define NIOS2_FP_JTAG_TLR_EN to walk the TAP through Test-Logic-Reset into RTI after reset
module nios2_fp_jtag_scan_master #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = nios2_fp_jtag_pkg::MAX_LEN
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_is_ir,
    input  logic [nios2_fp_jtag_pkg::LEN_W-1:0] cmd_len,
    input  logic [MAX_LEN-1:0]                  cmd_data,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [MAX_LEN-1:0]                  rsp_data,
    output logic                                busy,
    output logic                                tck,
    output logic                                tms,
    output logic                                tdi,
    input  logic                                tdo
);
    import nios2_fp_jtag_pkg::*;
`ifdef NIOS2_FP_JTAG_TLR_EN
    localparam state_t RST_STATE = TLR;
`else
    localparam state_t RST_STATE = IDLE;
`endif
    state_t state, state_n;
    logic tms_n, tdi_n, is_ir, ir_n, rise, fall, accept;
    logic [LEN_W-1:0] len, len_n, bit_cnt, bit_n, eff_len;
    logic [2:0] tlr_cnt, tlr_n;
    logic [MAX_LEN-1:0] dat, dat_n, rsp_n;
    assign eff_len = cmd_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : cmd_len;
    assign rsp_valid = state == RESP;
    assign cmd_ready = state == IDLE && !rsp_valid;
    assign busy = !(state == IDLE || state == RESP);
    assign accept = cmd_valid && cmd_ready;
    nios2_fp_jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (busy),
        .tck    (tck),
        .rise   (rise),
        .fall   (fall)
    );
    // Each state covers one TCK period; tms/tdi for the next period are set on the falling edge.
    always_comb begin
        state_n = state;
        tms_n = tms;
        tdi_n = tdi;
        ir_n = is_ir;
        len_n = len;
        bit_n = bit_cnt;
        tlr_n = tlr_cnt;
        dat_n = dat;
        rsp_n = rsp_data;
        if (accept) begin
            ir_n = cmd_is_ir;
            len_n = eff_len;
            dat_n = cmd_data;
            rsp_n = '0;
            bit_n = '0;
            tms_n = 1'b1;
            tdi_n = 1'b0;
            state_n = eff_len == '0 ? RESP : SEL_DR;
        end
        if (state == RESP && rsp_ready)
            state_n = IDLE;
        if (rise && state == SHIFT)
            rsp_n[bit_cnt] = tdo;
        if (fall) begin
            case (state)
                TLR: begin
                    tlr_n = tlr_cnt + 3'd1;
                    if (tlr_cnt == 3'(TLR_CYCLES - 1)) begin
                        state_n = TLR_RTI;
                        tms_n = 1'b0;
                    end
                end
                TLR_RTI: state_n = IDLE;
                SEL_DR: begin
                    state_n = is_ir ? SEL_IR : CAPTURE;
                    tms_n = is_ir;
                end
                SEL_IR: begin
                    state_n = CAPTURE;
                    tms_n = 1'b0;
                end
                CAPTURE: begin
                    state_n = SHIFT;
                    tms_n = len == LEN_W'(1);
                    tdi_n = dat[0];
                end
                SHIFT: begin
                    if (bit_cnt == len - LEN_W'(1)) begin
                        state_n = EXIT1;
                        tms_n = 1'b1;
                        tdi_n = 1'b0;
                    end else begin
                        bit_n = bit_cnt + LEN_W'(1);
                        tdi_n = dat[bit_n];
                        tms_n = bit_n == len - LEN_W'(1);
                    end
                end
                EXIT1: begin
                    state_n = UPDATE;
                    tms_n = 1'b0;
                end
                UPDATE: state_n = RUN_IDLE;
                RUN_IDLE: state_n = RESP;
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RST_STATE;
            tms <= 1'b1;
            tdi <= 1'b0;
            is_ir <= 1'b0;
            len <= '0;
            bit_cnt <= '0;
            tlr_cnt <= '0;
            dat <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_n;
            tms <= tms_n;
            tdi <= tdi_n;
            is_ir <= ir_n;
            len <= len_n;
            bit_cnt <= bit_n;
            tlr_cnt <= tlr_n;
            dat <= dat_n;
            rsp_data <= rsp_n;
        end
    end
endmodule
